// File: rtl/uart_io_sched_pkg.sv
// uart_io_sched_pkg
//   Shared definitions for the miniuart2 bus scheduler: scheduler state
//   encoding, UART register addresses and the default status bit indices.
package uart_io_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_CHECK,
        ST_RD,
        ST_RCAP,
        ST_WR
    } state_t;

    // miniuart2 register map (io_addr)
    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STAT = 1'b1;

    // Default status register bit positions
    localparam int RX_BIT_DEF     = 0;  // 1 = receive byte available
    localparam int TXBUSY_BIT_DEF = 1;  // 1 = transmitter busy

endpackage

// File: rtl/uart_io_sched_if.sv
// uart_io_sched_if
//   Bundles the requester handshakes, the rx output and the miniuart2
//   register bus of uart_io_sched.
//   master : scheduler side (drives readies, rx, UART strobes, busy)
//   slave  : requesters + UART side (drives valids/data and io_dout)
//   Signals:
//     req0_valid/req0_data/req0_ready  CPU console byte handshake
//     req1_valid/req1_data/req1_ready  debug/monitor byte handshake
//     rx_valid/rx_data                 received byte output
//     io_rd/io_wr/io_addr/io_din       UART register strobes, address, write data
//     io_dout                          UART read data (cycle after io_rd)
//     busy                             scheduler not idle
interface uart_io_sched_if #(
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              io_rd;
    logic              io_wr;
    logic              io_addr;
    logic [DATA_W-1:0] io_din;
    logic [DATA_W-1:0] io_dout;
    logic              busy;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data, io_dout,
        output req0_ready, req1_ready, rx_valid, rx_data,
               io_rd, io_wr, io_addr, io_din, busy
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data, io_dout,
        input  req0_ready, req1_ready, rx_valid, rx_data,
               io_rd, io_wr, io_addr, io_din, busy
    );
endinterface

// File: rtl/uart_io_sched.sv
// uart_io_sched
//   Owns the miniuart2 register bus and shares it between two byte-transmit
//   requesters (0 = CPU console, 1 = debug). Polls the status register,
//   drains received bytes to rx_data/rx_valid, and writes a requester byte
//   only when the transmitter is free. Round-robin between requesters.
//   Ports:
//     clk     system clock
//     rst_in  asynchronous active-high reset
//     bus     uart_io_sched_if.master (requester handshakes, rx output,
//             UART strobes/address/data, busy)
module uart_io_sched
    import uart_io_sched_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int POLL_GAP   = 16,
    parameter int RX_BIT     = RX_BIT_DEF,
    parameter int TXBUSY_BIT = TXBUSY_BIT_DEF
) (
    input logic             clk,
    input logic             rst_in,
    uart_io_sched_if.master bus
);

    localparam int CNT_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(POLL_GAP - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  gap_cnt;
    logic              last_grant;   // requester granted most recently
    logic              sel;          // requester chosen in CHECK
    logic              grant;
    logic              any_req;
    logic              sel_valid;
    logic [DATA_W-1:0] rx_hold;

    logic              io_rd, io_wr, io_addr;
    logic [DATA_W-1:0] io_din;
    logic              rdy0, rdy1, rx_vld;

    assign any_req   = bus.req0_valid | bus.req1_valid;
    // On a tie the requester that was not served last wins.
    assign grant     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    assign sel_valid = sel ? bus.req1_valid : bus.req0_valid;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            rx_hold    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_IDLE) begin
                if (gap_cnt != '1)
                    gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
            if (state == ST_CHECK)
                sel <= grant;
            if (state == ST_WR && sel_valid)
                last_grant <= sel;
            if (state == ST_RCAP)
                rx_hold <= bus.io_dout;
        end
    end

    always_comb begin
        state_nxt = state;
        io_rd     = 1'b0;
        io_wr     = 1'b0;
        io_addr   = ADDR_DATA;
        io_din    = '0;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        rx_vld    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req || gap_cnt == GAP_LAST)
                    state_nxt = ST_POLL;
            end
            ST_POLL: begin
                io_rd     = 1'b1;
                io_addr   = ADDR_STAT;
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                // io_dout holds the status byte here; rx drains first to avoid overrun
                if (bus.io_dout[RX_BIT])
                    state_nxt = ST_RD;
                else if (!bus.io_dout[TXBUSY_BIT] && any_req)
                    state_nxt = ST_WR;
                else
                    state_nxt = ST_IDLE;
            end
            ST_RD: begin
                io_rd     = 1'b1;
                io_addr   = ADDR_DATA;
                state_nxt = ST_RCAP;
            end
            ST_RCAP: begin
                rx_vld    = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_WR: begin
                // A requester that withdrew after CHECK is not written
                if (sel_valid) begin
                    io_wr  = 1'b1;
                    io_din = sel ? bus.req1_data : bus.req0_data;
                    rdy0   = ~sel;
                    rdy1   = sel;
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.io_rd      = io_rd;
    assign bus.io_wr      = io_wr;
    assign bus.io_addr    = io_addr;
    assign bus.io_din     = io_din;
    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rx_valid   = rx_vld;
    // Present the byte in the same cycle as rx_valid, then hold it
    assign bus.rx_data    = (state == ST_RCAP) ? bus.io_dout : rx_hold;
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: doc/uart_io_sched.md
# uart_io_sched

Scheduler that owns the miniuart2 register bus and shares it between two byte-transmit requesters: the CPU console path (requester 0) and a debug/monitor path (requester 1). It polls the UART status register, drains received bytes to a single rx output, and issues transmit writes only when the UART reports the transmitter free. It sits between the requesters and miniuart2 in the top level, so no requester drives io_rd or io_wr directly.

## Interface
- DATA_W, 8, UART data width (io_din, io_dout, request and rx data)
- POLL_GAP, 16, idle cycles between background status polls (rx drain when no tx pending); minimum 1
- RX_BIT, 0, status bit index: 1 = receive byte available
- TXBUSY_BIT, 1, status bit index: 1 = transmitter busy
- Clock and reset: clk is the clock; rst_in is the reset, asynchronous, active-high.
- clk  in  1  system clock (50 MHz domain)
- rst_in  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 (CPU) has a byte to send
- req0_data  in  DATA_W  requester 0 byte; held stable while req0_valid=1
- req0_ready  out  1  one-cycle pulse: req0 byte accepted (written to UART)
- req1_valid  in  1  requester 1 (debug) has a byte to send
- req1_data  in  DATA_W  requester 1 byte
- req1_ready  out  1  one-cycle pulse: req1 byte accepted
- rx_valid  out  1  one-cycle pulse: rx_data holds a received byte
- rx_data  out  DATA_W  last received byte; holds until next rx_valid
- io_rd  out  1  UART read strobe
- io_wr  out  1  UART write strobe
- io_addr  out  1  0 = data register, 1 = status register
- io_din  out  DATA_W  write data to UART
- io_dout  in  DATA_W  UART read data, valid the cycle after io_rd
- busy  out  1  1 when state is not IDLE

## Operation
- States: IDLE, POLL, CHECK, RD, RCAP, WR.
- IDLE: gap counter counts up. Go to POLL when any reqN_valid=1 or the counter reaches POLL_GAP-1. The counter clears on leaving IDLE.
- POLL: io_rd=1, io_addr=1 for one cycle; then CHECK.
- CHECK: register io_dout as status.
  - RX_BIT=1: go to RD. Rx has priority over tx to avoid overrun.
  - Else TXBUSY_BIT=0 and a request is pending: go to WR with the selected requester latched.
  - Else: go to IDLE.
- RD: io_rd=1, io_addr=0 for one cycle; then RCAP.
- RCAP: rx_data<=io_dout, rx_valid=1; go to IDLE. A pending tx waits for the next poll.
- WR: io_wr=1, io_addr=0, io_din=data of the latched requester. reqN_ready=1 in the same cycle; then IDLE.
- Arbitration is round-robin with a 1-bit last-grant pointer, evaluated in CHECK.
  - Both valid: grant the requester that is not last-granted.
  - One valid: grant it.
  - The pointer updates only in WR.
- A requester that drops valid before being accepted is simply not granted. Data is sampled in WR, not latched earlier.
- Strobes are mutually exclusive and exactly one cycle wide. io_addr and io_din are 0 whenever no strobe is active.

## Timing
- Reset (async, any state): state=IDLE, gap counter=0, pointer=1 (so req0 wins the first tie).
- Reset values of outputs: io_rd=0, io_wr=0, io_addr=0, io_din=0, req0_ready=0, req1_ready=0, rx_valid=0, rx_data=0, busy=0.
- Reset mid-WR or mid-RD aborts the transaction with no ready or rx_valid pulse.
- Tx latency from reqN_valid rising in IDLE with UART free: POLL at cycle 1, CHECK at 2, WR/ready at 3. Minimum 4 cycles per byte including the return to IDLE.
- Rx latency from the poll that sees RX_BIT: RD one cycle after CHECK, rx_valid two cycles after CHECK.
- Background poll period when idle with no requests: POLL_GAP+2 cycles (IDLE dwell + POLL + CHECK).
- A simultaneous rx-available and tx request is serviced as rx first, then tx on the following poll.
- The gap counter saturates; no wrap-around affects behaviour.

## Structure
- Shared package/define header: state encoding, UART register addresses (ADDR_DATA=0, ADDR_STAT=1), default status bit indices.
- Single module with no sub-modules. The round-robin arbiter is inline since it is only 2 requesters.
- Top level instantiates it between cpu_top's UART port, the debug source and miniuart2.

## Test plan
- Reset: assert rst_in mid-WR → all outputs 0 immediately, no req0_ready pulse; after release the first poll occurs POLL_GAP+1 cycles later.
- Single tx: status=0x00, req0_valid with data 0x41 → io_wr at cycle 3 with io_din=0x41, io_addr=0; req0_ready pulses once.
- Tx busy: status=0x02 for 3 polls then 0x00, req1 byte 0x55 → no io_wr until the 4th poll, then exactly one write of 0x55.
- Round-robin: both valid continuously, status=0x00, req0 data 0xA0, req1 data 0xB1 → writes alternate 0xA0, 0xB1, 0xA0, …; grant counts differ by ≤1.
- Rx priority: status=0x01 with data register 0x7E, req0 pending → RD before WR; rx_valid with rx_data=0x7E precedes req0_ready.
- Background rx: no requests, UART receives 0x33 → rx_valid within POLL_GAP+5 cycles with rx_data=0x33; rx_data holds afterwards.
